// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - FSM encoding, SSD1306 command constants and init ROM for the LCD SPI engine
package lcd_pkg;

  localparam logic [2:0] ST_RST_LOW  = 3'd0;
  localparam logic [2:0] ST_RST_WAIT = 3'd1;
  localparam logic [2:0] ST_INIT     = 3'd2;
  localparam logic [2:0] ST_IDLE     = 3'd3;
  localparam logic [2:0] ST_SHIFT    = 3'd4;
  localparam logic [2:0] ST_HOLD     = 3'd5;

  localparam logic [7:0] CMD_DISP_OFF        = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON         = 8'hAF;
  localparam logic [7:0] CMD_SET_CLK_DIV     = 8'hD5;
  localparam logic [7:0] CMD_SET_MUX         = 8'hA8;
  localparam logic [7:0] CMD_SET_OFFSET      = 8'hD3;
  localparam logic [7:0] CMD_START_LINE      = 8'h40;
  localparam logic [7:0] CMD_SET_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] CMD_ADDR_MODE       = 8'h20;
  localparam logic [7:0] CMD_SEG_REMAP       = 8'hA1;
  localparam logic [7:0] CMD_COM_SCAN_DEC    = 8'hC8;
  localparam logic [7:0] CMD_COM_PINS        = 8'hDA;
  localparam logic [7:0] CMD_CONTRAST        = 8'h81;
  localparam logic [7:0] CMD_PRECHARGE       = 8'hD9;
  localparam logic [7:0] CMD_VCOM_DESELECT   = 8'hDB;
  localparam logic [7:0] CMD_RESUME_RAM      = 8'hA4;
  localparam logic [7:0] CMD_NORMAL_DISP     = 8'hA6;

  localparam int ROM_DEPTH = 25;

  // SSD1306 128x64 bring-up, arguments follow their command byte
  localparam logic [7:0] INIT_ROM [ROM_DEPTH] = '{
    CMD_DISP_OFF,
    CMD_SET_CLK_DIV, 8'h80,
    CMD_SET_MUX, 8'h3F,
    CMD_SET_OFFSET, 8'h00,
    CMD_START_LINE,
    CMD_SET_CHARGE_PUMP, 8'h14,
    CMD_ADDR_MODE, 8'h00,
    CMD_SEG_REMAP,
    CMD_COM_SCAN_DEC,
    CMD_COM_PINS, 8'h12,
    CMD_CONTRAST, 8'hCF,
    CMD_PRECHARGE, 8'hF1,
    CMD_VCOM_DESELECT, 8'h40,
    CMD_RESUME_RAM,
    CMD_NORMAL_DISP,
    CMD_DISP_ON
  };

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_spi_shifter.sv
// rtl/lcd_spi_shifter.sv - mode-0 MSB-first shift register with clock divider and bit counter
module lcd_spi_shifter
  import lcd_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              sclk,
  output logic              mosi,
  output logic              done
);

  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam int BIT_W = cnt_w(DATA_W);

  logic              active;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] sreg;
  logic              edge_now;

  assign edge_now = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  // done coincides with the final falling edge so the FSM moves to HOLD on that cycle
  assign done     = edge_now && sclk && (bit_cnt == BIT_W'(DATA_W - 1));
  assign mosi     = sreg[DATA_W-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
    end else if (load) begin
      active  <= 1'b1;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= data;
    end else if (edge_now) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
      if (sclk) begin
        sreg <= sreg << 1;
        if (done) begin
          bit_cnt <= '0;
          active  <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
    end else if (active) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/lcd_spi_engine.sv
// rtl/lcd_spi_engine.sv - SSD1306 4-wire SPI transmit engine with panel reset; LCD_INIT_ROM_EN adds built-in init
module lcd_spi_engine
  import lcd_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 27000,
  parameter int CS_HOLD    = 2,
  parameter int INIT_LEN   = 25
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_dc,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_init_done,
  output logic              o_rst,
  output logic              o_cs,
  output logic              o_dc,
  output logic              o_clk,
  output logic              o_data
);

  localparam int TMR_W  = cnt_w(RST_CYCLES);
  localparam int HOLD_W = cnt_w(CS_HOLD);

  if (CLK_DIV < 1 || CS_HOLD < 1 || RST_CYCLES < 1 || INIT_LEN < 1 || INIT_LEN > ROM_DEPTH) begin : g_bad_param
    $error("lcd_spi_engine: illegal parameter value");
  end

  logic [2:0]        state;
  logic [TMR_W-1:0]  timer;
  logic [HOLD_W-1:0] hold_cnt;
  logic              dc_q;
  logic              init_done_q;
  logic              accept;
  logic              load;
  logic [DATA_W-1:0] load_word;
  logic              sh_done;
  logic              init_active;
  logic              init_load;
  logic              init_next;
  logic [DATA_W-1:0] init_word;

`ifdef LCD_INIT_ROM_EN
  localparam int IDX_W = cnt_w(INIT_LEN);
  logic [IDX_W-1:0] init_idx;
  logic             init_active_q;

  assign init_active = init_active_q;
  assign init_next   = (state == ST_HOLD) && (hold_cnt == '0) && init_active_q
                       && (init_idx != IDX_W'(INIT_LEN - 1));
  assign init_load   = (state == ST_INIT) || init_next;
  assign init_word   = DATA_W'(INIT_ROM[init_next ? init_idx + IDX_W'(1) : init_idx]);
`else
  assign init_active = 1'b0;
  assign init_next   = 1'b0;
  assign init_load   = 1'b0;
  assign init_word   = '0;
`endif

  // one acceptance slot in HOLD lets the next word follow with CS still low
  assign o_ready   = ((state == ST_IDLE) || (state == ST_HOLD && hold_cnt == '0)) && !init_active;
  assign accept    = i_valid && o_ready;
  assign load      = accept || init_load;
  assign load_word = init_load ? init_word : i_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_RST_LOW;
      timer       <= '0;
      hold_cnt    <= '0;
      dc_q        <= 1'b0;
      init_done_q <= 1'b0;
`ifdef LCD_INIT_ROM_EN
      init_idx      <= '0;
      init_active_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RST_LOW: begin
          if (timer == TMR_W'(RST_CYCLES - 1)) begin
            timer <= '0;
            state <= ST_RST_WAIT;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_RST_WAIT: begin
          if (timer == TMR_W'(RST_CYCLES - 1)) begin
            timer <= '0;
`ifdef LCD_INIT_ROM_EN
            state         <= ST_INIT;
            init_idx      <= '0;
            init_active_q <= 1'b1;
`else
            state       <= ST_IDLE;
            init_done_q <= 1'b1;
`endif
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_INIT: begin
          dc_q  <= 1'b0;
          state <= ST_SHIFT;
        end
        ST_IDLE: begin
          if (accept) begin
            dc_q  <= i_dc;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            hold_cnt <= '0;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (accept) begin
            dc_q  <= i_dc;
            state <= ST_SHIFT;
          end else if (init_next) begin
`ifdef LCD_INIT_ROM_EN
            init_idx <= init_idx + IDX_W'(1);
`endif
            dc_q  <= 1'b0;
            state <= ST_SHIFT;
          end else if (hold_cnt == HOLD_W'(CS_HOLD - 1)) begin
            state       <= ST_IDLE;
            init_done_q <= 1'b1;
`ifdef LCD_INIT_ROM_EN
            init_active_q <= 1'b0;
`endif
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= ST_RST_LOW;
      endcase
    end
  end

  lcd_spi_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .load  (load),
    .data  (load_word),
    .sclk  (o_clk),
    .mosi  (o_data),
    .done  (sh_done)
  );

  assign o_rst       = (state != ST_RST_LOW);
  assign o_cs        = !((state == ST_SHIFT) || (state == ST_HOLD));
  assign o_busy      = (state == ST_SHIFT) || (state == ST_HOLD);
  assign o_dc        = dc_q;
  assign o_init_done = init_done_q;

endmodule

// File: tb/tb_lcd_spi_engine.sv
// tb/tb_lcd_spi_engine.sv - directed vector bench for lcd_spi_engine (CLK_DIV=2, RST_CYCLES=16, CS_HOLD=2)
module tb_lcd_spi_engine;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_dc = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready, o_busy, o_init_done, o_rst, o_cs, o_dc, o_clk, o_data;

  always #5 clk = ~clk;

  lcd_spi_engine #(
    .DATA_W     (8),
    .CLK_DIV    (2),
    .RST_CYCLES (16),
    .CS_HOLD    (2),
    .INIT_LEN   (25)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_dc        (i_dc),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_busy      (o_busy),
    .o_init_done (o_init_done),
    .o_rst       (o_rst),
    .o_cs        (o_cs),
    .o_dc        (o_dc),
    .o_clk       (o_clk),
    .o_data      (o_data)
  );

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [7:0] exp_bits;
    logic [7:0] exp_dcs;
    int         exp_cs_low;
  } vec_t;

  int total = 0;
  int bad = 0;

  // panel-side monitor: samples MOSI/DC at each o_clk rise and measures CS-low runs
  logic [1:0] rise_q[$];
  int   cs_rises = 0;
  int   cs_run = 0;
  int   last_run = 0;
  logic prev_clk = 1'b0;

  always @(negedge clk) begin
    if (o_clk === 1'b1 && prev_clk === 1'b0) rise_q.push_back({o_data, o_dc});
    prev_clk = o_clk;
    if (o_cs === 1'b0) cs_run++;
    else if (cs_run != 0) begin
      last_run = cs_run;
      cs_rises++;
      cs_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_seq(input string tag);
    int n = 0;
    int m = 0;
    while (o_rst !== 1'b1 && n < 100) begin n++; tick(); end
    check({tag, "_rst_low_len"}, n, 16);
    while (o_ready !== 1'b1 && m < 100) begin m++; tick(); end
    check({tag, "_ready_delay"}, m, 16);
    check({tag, "_init_done"}, o_init_done, 1);
  endtask

  task automatic send(input logic [7:0] d, input logic dc);
    int n = 0;
    while (o_ready !== 1'b1 && n < 300) begin n++; tick(); end
    check("send_ready", o_ready, 1);
    i_valid = 1'b1;
    i_data  = d;
    i_dc    = dc;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_cs(input string tag, input int base);
    int n = 0;
    while (cs_rises <= base && n < 400) begin n++; tick(); end
    check({tag, "_cs_release"}, cs_rises - base, 1);
  endtask

  task automatic grab(input int start, output logic [7:0] bits, output logic [7:0] dcs);
    bits = 8'h00;
    dcs  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (start + i < rise_q.size()) begin
        bits = {bits[6:0], rise_q[start + i][1]};
        dcs  = {dcs[6:0], rise_q[start + i][0]};
      end
    end
  endtask

  vec_t vecs[4];

  initial begin
    logic [7:0] bits, dcs;
    int rbase, cbase, n;

    vecs[0] = '{data: 8'hA5, dc: 1'b0, exp_bits: 8'b1010_0101, exp_dcs: 8'h00, exp_cs_low: 34};
    vecs[1] = '{data: 8'h5A, dc: 1'b1, exp_bits: 8'b0101_1010, exp_dcs: 8'hFF, exp_cs_low: 34};
    vecs[2] = '{data: 8'h80, dc: 1'b0, exp_bits: 8'b1000_0000, exp_dcs: 8'h00, exp_cs_low: 34};
    vecs[3] = '{data: 8'h01, dc: 1'b1, exp_bits: 8'b0000_0001, exp_dcs: 8'hFF, exp_cs_low: 34};

    repeat (3) tick();
    check("reset_outputs", {o_rst, o_cs, o_clk, o_data, o_dc, o_ready, o_busy, o_init_done}, 8'b0100_0000);
    i_rst = 1'b0;
    reset_seq("por");

    for (int v = 0; v < 4; v++) begin
      rbase = rise_q.size();
      cbase = cs_rises;
      send(vecs[v].data, vecs[v].dc);
      check("busy_after_accept", o_busy, 1);
      wait_cs("vec", cbase);
      grab(rbase, bits, dcs);
      check("vec_rises", rise_q.size() - rbase, 8);
      check("vec_mosi", bits, vecs[v].exp_bits);
      check("vec_dc", dcs, vecs[v].exp_dcs);
      check("vec_cs_low", last_run, vecs[v].exp_cs_low);
    end

    // back-to-back: CS stays low across both words, DC switches between them
    rbase = rise_q.size();
    cbase = cs_rises;
    send(8'h3C, 1'b0);
    send(8'hFF, 1'b1);
    wait_cs("b2b", cbase);
    check("b2b_rises", rise_q.size() - rbase, 16);
    grab(rbase, bits, dcs);
    check("b2b_w0_mosi", bits, 8'h3C);
    check("b2b_w0_dc", dcs, 8'h00);
    grab(rbase + 8, bits, dcs);
    check("b2b_w1_mosi", bits, 8'hFF);
    check("b2b_w1_dc", dcs, 8'hFF);
    check("b2b_cs_low", last_run, 67);

    // i_valid held during SHIFT is only taken in the HOLD slot
    rbase = rise_q.size();
    cbase = cs_rises;
    send(8'hC3, 1'b0);
    i_valid = 1'b1;
    i_data  = 8'h00;
    i_dc    = 1'b1;
    tick();
    check("ready_in_shift", o_ready, 0);
    n = 0;
    while (o_ready !== 1'b1 && n < 300) begin n++; tick(); end
    check("ready_in_hold", o_ready, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    wait_cs("hold", cbase);
    repeat (20) tick();
    check("hold_rises_once", rise_q.size() - rbase, 16);
    grab(rbase, bits, dcs);
    check("hold_w0_mosi", bits, 8'hC3);
    grab(rbase + 8, bits, dcs);
    check("hold_w1_mosi", bits, 8'h00);
    check("hold_w1_dc", dcs, 8'hFF);

    // reset in the middle of a word
    rbase = rise_q.size();
    send(8'hFF, 1'b1);
    n = 0;
    while (rise_q.size() - rbase < 4 && n < 200) begin n++; tick(); end
    check("abort_reached_bit4", rise_q.size() - rbase, 4);
    i_rst = 1'b1;
    tick();
    check("abort_pins", {o_cs, o_clk, o_rst, o_ready, o_busy}, 5'b10000);
    tick();
    i_rst = 1'b0;
    reset_seq("abort");
    check("abort_no_extra_bits", rise_q.size() - rbase, 4);

    rbase = rise_q.size();
    cbase = cs_rises;
    send(8'hA5, 1'b0);
    wait_cs("post", cbase);
    grab(rbase, bits, dcs);
    check("post_mosi", bits, 8'hA5);
    check("post_cs_low", last_run, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
